// File: rtl/adau1761_config_sequencer.sv
// ---------------------------------------------------------------------------
// adau1761_config_sequencer
//
// Runs the ADAU1761 configuration program. Each 9-bit command word is read
// from a registered ROM (10-bit address, 1-cycle read latency). A command can
// send an I2C byte or STOP through a valid/ready handshake to a byte engine,
// wait for a fixed delay or NOP time, wait for a status level, set a flag,
// or jump. Jumps let the program loop forever.
//
// Command encoding, decoded in this priority order:
//   1_bbbbbbbb  send byte b
//   0_11111111  send STOP
//   0_11101111  DELAY (DELAY_CYCLES)
//   0_11111110  NOP   (NOP_CYCLES)
//   0_101L000S  wait until status[S] == L
//   0_100V000F  flags[F] = V
//   0_0TTTTTTT  jump to {T,3'b000}
//   other       ERROR
//
// Optional build macro: ADAU_CFG_RETRY_EN
//   When defined, a NACK makes the sequencer issue a STOP and restart the
//   current transaction, up to MAX_RETRY times, before it gives up.
//   When undefined, any NACK goes straight to ERROR.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      one-cycle pulse; starts the program at address 0 (IDLE only)
//   rom_addr   configuration ROM address
//   rom_data   ROM word, valid one cycle after rom_addr changes
//   i2c_valid  request to the I2C byte engine
//   i2c_ready  engine accepts the request when valid && ready
//   i2c_data   byte to transmit
//   i2c_stop   the request is a STOP condition
//   i2c_nack   engine pulse: the last byte was not acknowledged
//   status     external levels tested by WAIT commands
//   flags      software-controlled flags
//   running    high outside IDLE and ERROR
//   error      sticky error; high in ERROR
// ---------------------------------------------------------------------------
module adau1761_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 1000000,
  parameter int unsigned NOP_CYCLES   = 16,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic [9:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic       i2c_valid,
  input  logic       i2c_ready,
  output logic [7:0] i2c_data,
  output logic       i2c_stop,
  input  logic       i2c_nack,
  input  logic [1:0] status,
  output logic [1:0] flags,
  output logic       running,
  output logic       error
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_FETCH  | rom_addr presented to the ROM
  // S_WAITROM| ROM read in flight
  // S_EXEC   | rom_data valid; decode and execute the command
  // S_SEND   | I2C request pending until the handshake
  // S_TIMER  | DELAY/NOP count-down
  // S_WAITST | waiting for status[sel] == level
  // S_ERROR  | stopped; leave only by reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAITROM, S_EXEC, S_SEND, S_TIMER, S_WAITST, S_ERROR
  } state_t;

  localparam int unsigned TMAX = (DELAY_CYCLES > NOP_CYCLES) ? DELAY_CYCLES : NOP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t        state_q, state_d;
  logic [9:0]    addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          stop_q, stop_d;
  logic [1:0]    flags_q, flags_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wsel_q, wsel_d;
  logic          wlvl_q, wlvl_d;
  logic [9:0]    addr_next;
  logic          active;

`ifdef ADAU_CFG_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  logic [9:0]    txn_addr_q, txn_addr_d;
  logic          txn_open_q, txn_open_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          rstop_q, rstop_d;
`endif

  assign addr_next = addr_q + 10'd1;  // wraps 1023 -> 0
  assign active    = (state_q != S_IDLE) && (state_q != S_ERROR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    stop_d  = stop_q;
    flags_d = flags_q;
    timer_d = timer_q;
    wsel_d  = wsel_q;
    wlvl_d  = wlvl_q;
`ifdef ADAU_CFG_RETRY_EN
    txn_addr_d = txn_addr_q;
    txn_open_d = txn_open_q;
    retry_d    = retry_q;
    rstop_d    = rstop_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = 10'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH:   state_d = S_WAITROM;
      S_WAITROM: state_d = S_EXEC;
      S_EXEC: begin
        if (rom_data[8]) begin
          data_d  = rom_data[7:0];
          stop_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_SEND;
`ifdef ADAU_CFG_RETRY_EN
          if (!txn_open_q) begin
            txn_addr_d = addr_q;
            txn_open_d = 1'b1;
          end
`endif
        end else if (rom_data[7:0] == 8'hFF) begin
          stop_d  = 1'b1;
          valid_d = 1'b1;
          state_d = S_SEND;
`ifdef ADAU_CFG_RETRY_EN
          txn_open_d = 1'b0;
`endif
        end else if (rom_data[7:0] == 8'hEF) begin
          timer_d = TW'(DELAY_CYCLES - 1);
          state_d = S_TIMER;
        end else if (rom_data[7:0] == 8'hFE) begin
          timer_d = TW'(NOP_CYCLES - 1);
          state_d = S_TIMER;
        end else if (rom_data[7:5] == 3'b101 && rom_data[3:1] == 3'b000) begin
          wsel_d  = rom_data[0];
          wlvl_d  = rom_data[4];
          state_d = S_WAITST;
        end else if (rom_data[7:5] == 3'b100 && rom_data[3:1] == 3'b000) begin
          flags_d[rom_data[0]] = rom_data[4];
          addr_d  = addr_next;
          state_d = S_FETCH;
        end else if (!rom_data[7]) begin
          addr_d  = {rom_data[6:0], 3'b000};
          state_d = S_FETCH;
`ifdef ADAU_CFG_RETRY_EN
          txn_open_d = 1'b0;
`endif
        end else begin
          state_d = S_ERROR;
        end
      end
      S_SEND: begin
        if (valid_q && i2c_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_next;
          state_d = S_FETCH;
`ifdef ADAU_CFG_RETRY_EN
          // A recovery STOP restarts at txn_start_addr, already in addr_q.
          if (rstop_q) begin
            addr_d  = addr_q;
            rstop_d = 1'b0;
          end else if (stop_q) begin
            retry_d = '0;
          end
`endif
        end
      end
      S_TIMER: begin
        if (timer_q == '0) begin
          addr_d  = addr_next;
          state_d = S_FETCH;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WAITST: begin
        if (status[wsel_q] == wlvl_q) begin
          addr_d  = addr_next;
          state_d = S_FETCH;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // NACK overrides whatever the state logic decided, including a
    // handshake in the same cycle.
    if (i2c_nack && active) begin
`ifdef ADAU_CFG_RETRY_EN
      if (retry_q >= RW'(MAX_RETRY)) begin
        valid_d = 1'b0;
        state_d = S_ERROR;
      end else begin
        retry_d = retry_q + RW'(1);
        valid_d = 1'b1;
        stop_d  = 1'b1;
        rstop_d = 1'b1;
        addr_d  = txn_addr_q;
        state_d = S_SEND;
      end
`else
      valid_d = 1'b0;
      state_d = S_ERROR;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= 10'd0;
      valid_q <= 1'b0;
      data_q  <= 8'd0;
      stop_q  <= 1'b0;
      flags_q <= 2'b00;
      timer_q <= '0;
      wsel_q  <= 1'b0;
      wlvl_q  <= 1'b0;
`ifdef ADAU_CFG_RETRY_EN
      txn_addr_q <= 10'd0;
      txn_open_q <= 1'b0;
      retry_q    <= '0;
      rstop_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      stop_q  <= stop_d;
      flags_q <= flags_d;
      timer_q <= timer_d;
      wsel_q  <= wsel_d;
      wlvl_q  <= wlvl_d;
`ifdef ADAU_CFG_RETRY_EN
      txn_addr_q <= txn_addr_d;
      txn_open_q <= txn_open_d;
      retry_q    <= retry_d;
      rstop_q    <= rstop_d;
`endif
    end
  end

  assign rom_addr  = addr_q;
  assign i2c_valid = valid_q;
  assign i2c_data  = data_q;
  assign i2c_stop  = stop_q;
  assign flags     = flags_q;
  assign running   = active;
  assign error     = (state_q == S_ERROR);

endmodule

// File: doc/adau1761_config_sequencer.md
Name: adau1761_config_sequencer

Overview:
- Program sequencer for the ADAU1761 codec configuration path on the Zedboard.
- Fetches 9-bit command words from the registered configuration ROM, with 10-bit address and 1-cycle read latency, and executes them.
- Drives a downstream I2C byte engine through a valid/ready handshake.
- Also provides delays, status waits, two flag outputs and jumps, so the ROM program can loop indefinitely.

Parameters:
- DELAY_CYCLES, 1000000: clk cycles consumed by a DELAY command.
- NOP_CYCLES, 16: clk cycles consumed by a NOP command.
- MAX_RETRY, 3: NACK retries per transaction; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at address 0 from IDLE.
- rom_addr  out  10  configuration ROM address.
- rom_data  in  9  ROM word, valid one cycle after rom_addr changes.
- i2c_valid  out  1  byte or stop request to the I2C engine.
- i2c_ready  in  1  engine accepts the request when valid and ready are both high in the same cycle.
- i2c_data  out  8  byte to transmit.
- i2c_stop  out  1  request is a STOP condition, not a byte.
- i2c_nack  in  1  pulse from the engine; the last byte was not acknowledged.
- status  in  2  external levels tested by WAIT commands.
- flags  out  2  software-controlled flags, for example codec-ready and LED.
- running  out  1  high outside IDLE and ERROR.
- error  out  1  sticky; high in ERROR.

Behaviour:
- Reset values: rom_addr=0, i2c_valid=0, i2c_data=0, i2c_stop=0, flags=0, running=0, error=0, state=IDLE.
- States: IDLE, FETCH, WAITROM, EXEC, SEND, TIMER, WAITST, ERROR.
- IDLE: on start, set rom_addr=0 and go to FETCH.
  - start is ignored in all other states.
- FETCH -> WAITROM -> EXEC.
  - This absorbs the ROM latency.
  - rom_data is sampled in EXEC.
- Command decode on rom_data, priority in this order:
  - 1_bbbbbbbb: i2c_data=b, i2c_stop=0, i2c_valid=1; go to SEND.
  - 0_11111111: i2c_stop=1, i2c_valid=1; go to SEND.
  - 0_11101111: load timer with DELAY_CYCLES-1; go to TIMER.
  - 0_11111110: load timer with NOP_CYCLES-1; go to TIMER.
  - 0_101L000S: go to WAITST; wait until status[S]==L.
  - 0_100V000F: flags[F]=V; advance.
  - 0_0TTTTTTT: rom_addr={TTTTTTT,3'b000}; go to FETCH.
  - Any other encoding: go to ERROR.
- Advance: rom_addr+1, wrapping 1023 -> 0; go to FETCH.
- SEND:
  - i2c_valid, i2c_data and i2c_stop hold stable until the handshake.
  - On handshake, drop i2c_valid and advance in the same cycle.
- TIMER: decrement each cycle; advance when the count is 0.
  - A DELAY therefore occupies exactly DELAY_CYCLES cycles in TIMER.
- WAITST: advance on the first cycle the condition is true.
  - A condition already true on entry costs 1 cycle.
- NACK:
  - i2c_nack in any state except IDLE/ERROR -> ERROR.
  - The optional feature changes this.
  - A NACK coincident with a handshake takes priority over advancing.
- ERROR: error=1, running=0, i2c_valid=0; flags are retained.
  - Leave ERROR only by reset.
- Reset mid-operation, including mid-handshake or mid-delay: all registers return to their reset values immediately.
- running=1 in FETCH, WAITROM, EXEC, SEND, TIMER and WAITST.

Optional Feature:
- Macro: ADAU_CFG_RETRY_EN.
- When defined:
  - The sequencer latches txn_start_addr, the address of the first byte command after each STOP or jump.
  - On NACK it drops i2c_valid, issues a STOP request and sets rom_addr=txn_start_addr.
  - It increments a per-transaction retry counter, which resets on each successful STOP.
  - It enters ERROR only when the counter exceeds MAX_RETRY.
- When undefined: a NACK goes directly to ERROR, and no retry logic or counter is synthesized.

Test Plan:
- Program 0x176,0x140,0x100,0x0FF with i2c_ready always 1 and a start pulse:
  - Bytes 0x76, 0x40, 0x00 are sent, then a STOP request, each with a 1-cycle handshake.
  - running stays high; no error.
- A byte command with i2c_ready held low for 5 cycles: i2c_valid and i2c_data=0x76 hold stable, and the sequencer advances only on the cycle ready rises.
- DELAY with DELAY_CYCLES=10: exactly 10 cycles in TIMER, then the fetch proceeds to the next address.
- 0x0B1 with status[1] low for 7 cycles, then high: 0x0B1 is the WAIT command for status[1]==1. The sequencer remains in WAITST until status[1]=1, then advances. Also cover 0x091, which sets flags[1]=1.
- A jump word 0x013 at address 0x071: the next rom_addr is 0x098. A jump word 0x022 at the end of the program loops to 0x110.
- NACK after the second byte (retry disabled): error=1, running=0, i2c_valid=0. Assert resetn low mid-DELAY: all outputs return to their reset values.
